// File: rtl/gb_timer_pkg.sv
// gb_timer_pkg: bus addresses, interrupt index and FSM encoding for the
// DIV/TIMA/TMA/TAC timer.
package gb_timer_pkg;

   localparam logic [15:0] ADDR_DIV  = 16'hFF04;
   localparam logic [15:0] ADDR_TIMA = 16'hFF05;
   localparam logic [15:0] ADDR_TMA  = 16'hFF06;
   localparam logic [15:0] ADDR_TAC  = 16'hFF07;

   localparam int I_TIMA = 2;

   typedef enum logic {
      TMR_RUN  = 1'b0,
      TMR_PEND = 1'b1
   } tmr_state_e;

   // Divider bit that clocks TIMA for a given TAC[1:0] rate select.
   function automatic logic tap_bit(
      input logic [15:0] cnt,
      input logic [1:0]  sel
   );
      logic b;
      case (sel)
         2'b00:   b = cnt[9];
         2'b01:   b = cnt[3];
         2'b10:   b = cnt[5];
         default: b = cnt[7];
      endcase
      return b;
   endfunction

endpackage

// File: rtl/gb_timer_edge_det.sv
// tmr_edge_det: registered 1->0 detector with a history preload port,
// synchronous active-low reset.
module tmr_edge_det (
   input  logic i_clk,
   input  logic i_rst_n,
   input  logic i_d,
   input  logic i_load,
   input  logic i_load_val,
   output logic o_fall
);

   logic r_prev;

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         r_prev <= 1'b0;
      end else if (i_load) begin
         r_prev <= i_load_val;
      end else begin
         r_prev <= i_d;
      end
   end

   assign o_fall = r_prev & ~i_d;

endmodule

// File: rtl/gb_timer.sv
// gb_timer: memory-mapped DIV/TIMA/TMA/TAC timer with delayed TMA reload.
// Define TIMER_GLITCH_EN for DMG-accurate spurious ticks on DIV/TAC writes.
module gb_timer #(
   parameter int RELOAD_DELAY = 1
) (
   input  logic        clock,
   input  logic        reset,
   input  logic [15:0] addr_ext,
   inout  wire  [7:0]  data_ext,
   input  logic        mem_we,
   input  logic        mem_re,
   output logic        int_req,
   output logic [7:0]  div_out
);

   import gb_timer_pkg::*;

   localparam logic [1:0] PEND_INIT = 2'(RELOAD_DELAY - 1);

   logic [15:0] r_sys_cnt;
   logic [15:0] w_cnt_nxt;
   logic [7:0]  r_tima;
   logic [7:0]  r_tma;
   logic [7:0]  w_tima_nxt;
   logic [7:0]  w_wdata;
   logic [7:0]  w_rdata;
   logic [2:0]  r_tac;
   logic [1:0]  r_pend_cnt;
   logic [1:0]  w_pend_nxt;
   tmr_state_e  r_state;
   tmr_state_e  w_state_nxt;
   logic        r_int;
   logic        w_int_nxt;

   logic w_sel_div;
   logic w_sel_tima;
   logic w_sel_tma;
   logic w_sel_tac;
   logic w_oe;
   logic w_wr_div;
   logic w_wr_tima;
   logic w_wr_tma;
   logic w_wr_tac;
   logic w_tap;
   logic w_edge_d;
   logic w_edge_ld;
   logic w_edge_ldv;
   logic w_fall;
   logic w_tick;

   assign w_sel_div  = (addr_ext == ADDR_DIV);
   assign w_sel_tima = (addr_ext == ADDR_TIMA);
   assign w_sel_tma  = (addr_ext == ADDR_TMA);
   assign w_sel_tac  = (addr_ext == ADDR_TAC);

   assign w_wr_div  = mem_we & w_sel_div;
   assign w_wr_tima = mem_we & w_sel_tima;
   assign w_wr_tma  = mem_we & w_sel_tma;
   assign w_wr_tac  = mem_we & w_sel_tac;

   assign w_wdata = data_ext;

   assign w_oe = mem_re &
      (w_sel_div | w_sel_tima | w_sel_tma | w_sel_tac);

   always_comb begin
      w_rdata = 8'h00;
      unique case (1'b1)
         w_sel_div:  w_rdata = r_sys_cnt[15:8];
         w_sel_tima: w_rdata = r_tima;
         w_sel_tma:  w_rdata = r_tma;
         w_sel_tac:  w_rdata = {5'b11111, r_tac};
         default:    w_rdata = 8'h00;
      endcase
   end

   assign data_ext = w_oe ? w_rdata : 8'hzz;

   assign w_cnt_nxt = w_wr_div ? 16'h0000 : r_sys_cnt + 16'd1;
   assign w_tap     = tap_bit(r_sys_cnt, r_tac[1:0]);

`ifdef TIMER_GLITCH_EN
   assign w_edge_d   = r_tac[2] & w_tap;
   assign w_edge_ld  = 1'b0;
   assign w_edge_ldv = 1'b0;
   assign w_tick     = w_fall;
`else
   // Preload history with next cycle's tap so DIV/TAC writes look edgeless.
   assign w_edge_d   = w_tap;
   assign w_edge_ld  = w_wr_div | w_wr_tac;
   assign w_edge_ldv = tap_bit(w_cnt_nxt,
                               w_wr_tac ? w_wdata[1:0] : r_tac[1:0]);
   assign w_tick     = w_fall & r_tac[2];
`endif

   tmr_edge_det u_edge (
      .i_clk      (clock),
      .i_rst_n    (reset),
      .i_d        (w_edge_d),
      .i_load     (w_edge_ld),
      .i_load_val (w_edge_ldv),
      .o_fall     (w_fall)
   );

   always_comb begin
      w_tima_nxt  = r_tima;
      w_state_nxt = r_state;
      w_pend_nxt  = r_pend_cnt;
      w_int_nxt   = 1'b0;
      case (r_state)
         TMR_RUN: begin
            if (w_wr_tima) begin
               w_tima_nxt = w_wdata;
            end else if (w_tick) begin
               if (r_tima == 8'hFF) begin
                  w_tima_nxt  = 8'h00;
                  w_state_nxt = TMR_PEND;
                  w_pend_nxt  = PEND_INIT;
               end else begin
                  w_tima_nxt = r_tima + 8'd1;
               end
            end
         end
         TMR_PEND: begin
            if (w_wr_tima) begin
               w_tima_nxt  = w_wdata;
               w_state_nxt = TMR_RUN;
            end else if (r_pend_cnt == 2'd0) begin
               // A TMA write landing on the reload clock is forwarded.
               w_tima_nxt  = w_wr_tma ? w_wdata : r_tma;
               w_int_nxt   = 1'b1;
               w_state_nxt = TMR_RUN;
            end else begin
               w_pend_nxt = r_pend_cnt - 2'd1;
            end
         end
      endcase
   end

   always_ff @(posedge clock) begin
      if (!reset) begin
         r_sys_cnt  <= 16'h0000;
         r_tima     <= 8'h00;
         r_tma      <= 8'h00;
         r_tac      <= 3'b000;
         r_state    <= TMR_RUN;
         r_pend_cnt <= 2'd0;
         r_int      <= 1'b0;
      end else begin
         r_sys_cnt  <= w_cnt_nxt;
         r_tima     <= w_tima_nxt;
         r_state    <= w_state_nxt;
         r_pend_cnt <= w_pend_nxt;
         r_int      <= w_int_nxt;
         if (w_wr_tma) begin
            r_tma <= w_wdata;
         end
         if (w_wr_tac) begin
            r_tac <= w_wdata[2:0];
         end
      end
   end

   assign int_req = r_int;
   assign div_out = r_sys_cnt[15:8];

endmodule

// File: tb/tb_gb_timer.sv
// tb_gb_timer: directed and randomized scoreboard bench for gb_timer.
// A cycle-level behavioural model supplies every read and int_req expectation.
module tb_gb_timer;

   localparam int RD = 1;

   localparam logic [15:0] A_DIV  = 16'hFF04;
   localparam logic [15:0] A_TIMA = 16'hFF05;
   localparam logic [15:0] A_TMA  = 16'hFF06;
   localparam logic [15:0] A_TAC  = 16'hFF07;

   logic        clock   = 1'b0;
   logic        reset   = 1'b0;
   logic [15:0] addr_ext = 16'h0000;
   logic        mem_we  = 1'b0;
   logic        mem_re  = 1'b0;
   logic        drv_en  = 1'b0;
   logic [7:0]  drv_val = 8'h00;
   wire  [7:0]  data_ext;
   logic        int_req;
   logic [7:0]  div_out;

   assign data_ext = drv_en ? drv_val : 8'hzz;

   gb_timer #(.RELOAD_DELAY(RD)) dut (
      .clock    (clock),
      .reset    (reset),
      .addr_ext (addr_ext),
      .data_ext (data_ext),
      .mem_we   (mem_we),
      .mem_re   (mem_re),
      .int_req  (int_req),
      .div_out  (div_out)
   );

   always #5 clock = ~clock;

   int unsigned m_cnt  = 0;
   logic [7:0]  m_tima = 8'h00;
   logic [7:0]  m_tma  = 8'h00;
   logic [2:0]  m_tac  = 3'b000;
   int          m_pend = -1;
   bit          m_hist = 1'b0;
   int          cyc    = 0;
   int          n_chk  = 0;
   int          n_fail = 0;
   int          q_int[$];
   logic [7:0]  q_rd[$];

   task automatic fail(input string name, input int act, input int exp);
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)",
               name, act, exp, cyc);
   endtask

   function automatic bit in_rng(input logic [15:0] a);
      return (a >= A_DIV) && (a <= A_TAC);
   endfunction

   function automatic bit tap_of(input int unsigned c, input logic [2:0] t);
      int k;
      case (t[1:0])
         2'd0:    k = 9;
         2'd1:    k = 3;
         2'd2:    k = 5;
         default: k = 7;
      endcase
      return ((c >> k) & 32'd1) == 32'd1;
   endfunction

   function automatic logic [7:0] model_rd(input logic [15:0] a);
      if (a == A_DIV)  return 8'((m_cnt >> 8) & 32'hFF);
      if (a == A_TIMA) return m_tima;
      if (a == A_TMA)  return m_tma;
      return {5'b11111, m_tac};
   endfunction

   task automatic model_step();
      bit          wr_div, wr_tima, wr_tma, wr_tac, fall, sig;
      int unsigned n_cnt;
      logic [2:0]  n_tac;
      cyc++;
      if (!reset) begin
         m_cnt = 0; m_tima = 8'h00; m_tma = 8'h00; m_tac = 3'b000;
         m_pend = -1; m_hist = 1'b0;
         return;
      end
      wr_div  = mem_we && addr_ext == A_DIV;
      wr_tima = mem_we && addr_ext == A_TIMA;
      wr_tma  = mem_we && addr_ext == A_TMA;
      wr_tac  = mem_we && addr_ext == A_TAC;
`ifdef TIMER_GLITCH_EN
      sig  = m_tac[2] && tap_of(m_cnt, m_tac);
      fall = m_hist && !sig;
`else
      sig  = tap_of(m_cnt, m_tac);
      fall = m_hist && !sig && m_tac[2];
`endif
      if (wr_tima) begin
         m_tima = drv_val;
         m_pend = -1;
      end else if (m_pend == 0) begin
         m_tima = wr_tma ? drv_val : m_tma;
         m_pend = -1;
         q_int.push_back(cyc);
      end else if (m_pend > 0) begin
         m_pend--;
      end else if (fall) begin
         if (m_tima == 8'hFF) begin
            m_tima = 8'h00;
            m_pend = RD - 1;
         end else begin
            m_tima = m_tima + 8'd1;
         end
      end
      n_cnt = wr_div ? 0 : (m_cnt + 1) % 65536;
      n_tac = wr_tac ? drv_val[2:0] : m_tac;
      if (wr_tma) m_tma = drv_val;
`ifdef TIMER_GLITCH_EN
      m_hist = sig;
`else
      m_hist = (wr_div || wr_tac) ? tap_of(n_cnt, n_tac) : sig;
`endif
      m_cnt = n_cnt;
      m_tac = n_tac;
   endtask

   always @(posedge clock) model_step();

   // Monitor: pops scoreboard entries whenever the DUT presents output.
   always @(negedge clock) begin
      logic [7:0] e;
      n_chk++;
      if (div_out !== 8'((m_cnt >> 8) & 32'hFF))
         fail("div_out", int'(div_out), int'((m_cnt >> 8) & 32'hFF));
      while (q_int.size() > 0 && q_int[0] < cyc) begin
         n_chk++;
         fail("int_req missing", 0, 1);
         void'(q_int.pop_front());
      end
      if (int_req) begin
         n_chk++;
         if (q_int.size() == 0 || q_int[0] != cyc)
            fail("int_req spurious", 1, 0);
         else
            void'(q_int.pop_front());
      end
      if (mem_re && !drv_en && in_rng(addr_ext)) begin
         n_chk++;
         if (q_rd.size() == 0) begin
            fail("read without expectation", int'(data_ext), 0);
         end else begin
            e = q_rd.pop_front();
            if (data_ext !== e)
               fail($sformatf("read %h", addr_ext), int'(data_ext), int'(e));
         end
      end
   end

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic set_idle();
      mem_we = 1'b0; mem_re = 1'b0; drv_en = 1'b0; addr_ext = 16'h0000;
   endtask

   task automatic set_rd(input logic [15:0] a, input logic [7:0] e);
      addr_ext = a; mem_re = 1'b1; mem_we = 1'b0; drv_en = 1'b0;
      if (in_rng(a)) q_rd.push_back(e);
   endtask

   task automatic set_wr(input logic [15:0] a, input logic [7:0] d);
      addr_ext = a; mem_we = 1'b1; mem_re = 1'b0;
      drv_en = 1'b1; drv_val = d;
   endtask

   task automatic rd_exp(input logic [15:0] a, input logic [7:0] e);
      step(); set_rd(a, e);
   endtask

   task automatic wr(input logic [15:0] a, input logic [7:0] d);
      step(); set_wr(a, d);
   endtask

   task automatic idle(input int n);
      repeat (n) begin step(); set_idle(); end
   endtask

   task automatic wait_pend(input string name);
      for (int i = 0; i < 64; i++) begin
         if (m_pend >= 0) return;
         step(); set_idle();
      end
      n_chk++;
      fail(name, 0, 1);
   endtask

   initial begin
      #2000000;
      n_chk++;
      fail("watchdog timeout", 0, 1);
      $fatal(1, "watchdog");
   end

   initial begin
      logic [7:0] exp_t;
      logic [7:0] d;
      logic [15:0] a;
      int r;

      reset = 1'b0;
      repeat (2) @(posedge clock);
      #1;
      reset = 1'b1;
      rd_exp(A_DIV, 8'h00);
      rd_exp(A_TIMA, 8'h00);
      rd_exp(A_TMA, 8'h00);
      rd_exp(A_TAC, 8'hF8);
      idle(250);
      rd_exp(A_DIV, 8'h00);
      rd_exp(A_DIV, 8'h01);

      // Out-of-range read: the bench's own drive must survive on the bus.
      step();
      addr_ext = 16'hFF08; mem_re = 1'b1; mem_we = 1'b0;
      drv_en = 1'b1; drv_val = 8'hA5;
      @(negedge clock);
      n_chk++;
      if (data_ext !== 8'hA5) fail("bus released at FF08", int'(data_ext), 'hA5);

      wr(A_DIV, 8'h5A);
      rd_exp(A_DIV, 8'h00);

      wr(A_TAC, 8'h05);
      wr(A_TIMA, 8'h00);
      idle(160);
      rd_exp(A_TIMA, 8'h0A);
      rd_exp(A_TAC, 8'hFD);

      wr(A_TAC, 8'h04);
      wr(A_TIMA, 8'h00);
      idle(1024);
      rd_exp(A_TIMA, 8'h01);

      wr(A_TMA, 8'hF0);
      wr(A_TAC, 8'h05);
      wr(A_TIMA, 8'hFF);
      wait_pend("overflow never reached");
      set_rd(A_TIMA, 8'h00);
      repeat (RD - 1) begin step(); set_rd(A_TIMA, 8'h00); end
      rd_exp(A_TIMA, 8'hF0);
      idle(2);

      wr(A_TIMA, 8'hFF);
      wait_pend("cancel overflow never reached");
      set_wr(A_TIMA, 8'h33);
      rd_exp(A_TIMA, 8'h33);
      idle(15);
      rd_exp(A_TIMA, 8'h34);

      wr(A_TMA, 8'h10);
      wr(A_TIMA, 8'hFF);
      wait_pend("tma overflow never reached");
      repeat (RD - 1) begin step(); set_idle(); end
      set_wr(A_TMA, 8'h77);
      rd_exp(A_TIMA, 8'h77);
      rd_exp(A_TMA, 8'h77);

      wr(A_TIMA, 8'hFF);
      wait_pend("reset overflow never reached");
      reset = 1'b0;
      step();
      reset = 1'b1;
      set_rd(A_TIMA, 8'h00);
      rd_exp(A_TAC, 8'hF8);
      rd_exp(A_TMA, 8'h00);
      idle(4);

      wr(A_TAC, 8'h05);
      wr(A_TIMA, 8'h40);
      for (int i = 0; i < 40; i++) begin
         step(); set_idle();
         if (((m_cnt >> 3) & 32'd1) == 32'd1) break;
      end
      exp_t = m_tima;
      set_wr(A_DIV, 8'h00);
      step(); set_idle();
`ifdef TIMER_GLITCH_EN
      rd_exp(A_TIMA, exp_t + 8'd1);
`else
      rd_exp(A_TIMA, exp_t);
`endif

      for (int i = 0; i < 4000; i++) begin
         step();
         reset = 1'b1;
         r = $urandom_range(0, 99);
         if (r < 55) begin
            set_idle();
         end else if (r < 75) begin
            a = 16'hFF03 + 16'($urandom_range(0, 5));
            set_rd(a, model_rd(a));
         end else if (r < 98) begin
            a = A_DIV + 16'($urandom_range(0, 3));
            d = 8'($urandom);
            if (a == A_TIMA && $urandom_range(0, 1) == 1)
               d = 8'(8'hFD + $urandom_range(0, 2));
            if (a == A_TAC)
               d = {5'($urandom), 1'($urandom_range(0, 4) != 0), 2'($urandom)};
            set_wr(a, d);
         end else begin
            set_idle();
            reset = 1'b0;
         end
      end
      step();
      reset = 1'b1;
      set_idle();
      idle(6);

      n_chk++;
      if (q_rd.size() != 0) fail("read queue drain", q_rd.size(), 0);
      n_chk++;
      if (q_int.size() != 0) fail("int queue drain", q_int.size(), 0);

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule
